// File: rtl/ans_pkg.sv
// ans_pkg: constants and types shared by the ANS codec blocks
// (histogram, encoder, decoder, count loader).
//   SYM_WIDTH / SYM_COUNT : symbol alphabet width and size
//   CNT_WIDTH             : normalized frequency count width
//   hist_state_e          : histogram builder state encoding
package ans_pkg;

   localparam int unsigned SYM_WIDTH = 4;
   localparam int unsigned SYM_COUNT = 2 ** SYM_WIDTH;
   localparam int unsigned CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_COUNT = 2'd0,
      ST_SCAN  = 2'd1,
      ST_EMIT  = 2'd2
   } hist_state_e;

endpackage

// File: rtl/ans_histogram_if.sv
// ans_histogram_if: symbol input stream plus normalized-count output stream
// of the histogram builder.
//   in, in_last, in_vld / in_rdy : symbol stream (master -> slave)
//   out, out_vld / out_rdy       : count table stream (slave -> master)
//   busy                         : builder is scanning or emitting
// Modports: master (producer/consumer side), slave (histogram block).
interface ans_histogram_if;
   import ans_pkg::*;

   logic [SYM_WIDTH-1:0] in;
   logic                 in_last;
   logic                 in_vld;
   logic                 in_rdy;
   logic [CNT_WIDTH-1:0] out;
   logic                 out_vld;
   logic                 out_rdy;
   logic                 busy;

   modport master (
      output in, in_last, in_vld, out_rdy,
      input  in_rdy, out, out_vld, busy
   );

   modport slave (
      input  in, in_last, in_vld, out_rdy,
      output in_rdy, out, out_vld, busy
   );

endinterface

// File: rtl/ans_hist_norm.sv
// ans_hist_norm: combinational count normalizer.
//   r     : raw symbol count
//   s     : right-shift amount
//   cnt_c : normalized count; 0 only for an absent symbol, otherwise
//           clamped into 1 .. 2**CNT_WIDTH-1
// Build option: ANS_HIST_ROUND_EN selects round-half-up instead of truncation.
module ans_hist_norm
   import ans_pkg::*;
#(
   parameter int unsigned RAW_WIDTH   = 8,
   parameter int unsigned SHIFT_WIDTH = 4
) (
   input  logic [RAW_WIDTH-1:0]   r,
   input  logic [SHIFT_WIDTH-1:0] s,
   output logic [CNT_WIDTH-1:0]   cnt_c
);

   localparam int unsigned SUM_WIDTH = RAW_WIDTH + 1;
   localparam logic [SUM_WIDTH-1:0] CNT_MAX = SUM_WIDTH'(2 ** CNT_WIDTH - 1);

   logic [SUM_WIDTH-1:0] sum;
   logic [SUM_WIDTH-1:0] q;

`ifdef ANS_HIST_ROUND_EN
   // Add half an LSB of the shifted result before shifting.
   always_comb begin
      sum = {1'b0, r};
      if (s != '0) begin
         sum = {1'b0, r} + (SUM_WIDTH'(1) << (s - SHIFT_WIDTH'(1)));
      end
   end
`else
   assign sum = {1'b0, r};
`endif

   assign q = sum >> s;

   // Present symbols never collapse to zero probability.
   always_comb begin
      cnt_c = '0;
      if (r == '0) begin
         cnt_c = '0;
      end else if (q == '0) begin
         cnt_c = CNT_WIDTH'(1);
      end else if (q > CNT_MAX) begin
         cnt_c = '1;
      end else begin
         cnt_c = q[CNT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/ans_histogram.sv
// ans_histogram: builds the normalized symbol frequency table for one block.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ans_histogram_if.slave
//              in/in_last/in_vld/in_rdy  symbol stream, block ends on in_last
//              out/out_vld/out_rdy       16 normalized counts, symbol 0 first
//              busy                      high while scanning or emitting
// Flow: COUNT (saturating raw counters) -> SCAN (16 cycles of max search plus
// one cycle to load the first count) -> EMIT (one count per accepted beat).
// Build option: ANS_HIST_ROUND_EN (see ans_hist_norm).
module ans_histogram
   import ans_pkg::*;
#(
   parameter int unsigned RAW_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   ans_histogram_if.slave bus
);

   localparam int unsigned IDX_WIDTH   = SYM_WIDTH + 1;
   localparam int unsigned SHIFT_WIDTH = $clog2(RAW_WIDTH + 1);
   localparam logic [RAW_WIDTH-1:0] RAW_MAX  = '1;
   localparam logic [SYM_WIDTH-1:0] LAST_SYM = '1;

   hist_state_e            state;
   logic [RAW_WIDTH-1:0]   raw [SYM_COUNT];
   logic [IDX_WIDTH-1:0]   idx;
   logic [RAW_WIDTH-1:0]   max_q;
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic                   in_rdy_q;
   logic                   out_vld_q;
   logic                   busy_q;
   logic [CNT_WIDTH-1:0]   out_q;

   logic [SYM_WIDTH-1:0]   pos;
   logic                   scan_tail;
   logic [RAW_WIDTH-1:0]   scan_max;
   logic [SYM_WIDTH-1:0]   norm_sel;
   logic [CNT_WIDTH-1:0]   norm_val;

   // Shift that brings the largest count into CNT_WIDTH bits.
   function automatic logic [SHIFT_WIDTH-1:0] calc_shift(input logic [RAW_WIDTH-1:0] m);
      int unsigned len;
      len = 0;
      for (int unsigned b = 0; b < RAW_WIDTH; b++) begin
         if (m[b]) len = b + 1;
      end
      if (len > CNT_WIDTH) return SHIFT_WIDTH'(len - CNT_WIDTH);
      return '0;
   endfunction

   // idx[SYM_WIDTH] marks the extra SCAN cycle that preloads the first count.
   assign pos       = idx[SYM_WIDTH-1:0];
   assign scan_tail = idx[SYM_WIDTH];

   // Running max and normalizer address: the registered output is loaded
   // one entry ahead of the emit index.
   always_comb begin
      scan_max = max_q;
      if (raw[pos] > max_q) scan_max = raw[pos];
      norm_sel = '0;
      if (state == ST_EMIT) norm_sel = pos + SYM_WIDTH'(1);
   end

   ans_hist_norm #(
      .RAW_WIDTH   (RAW_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_norm (
      .r     (raw[norm_sel]),
      .s     (shift_q),
      .cnt_c (norm_val)
   );

   // Control FSM, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_COUNT;
         idx       <= '0;
         max_q     <= '0;
         shift_q   <= '0;
         in_rdy_q  <= 1'b0;
         out_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         out_q     <= '0;
         for (int unsigned k = 0; k < SYM_COUNT; k++) raw[k] <= '0;
      end else begin
         case (state)
            ST_COUNT: begin
               in_rdy_q <= 1'b1;
               if (bus.in_vld && in_rdy_q) begin
                  if (raw[bus.in] != RAW_MAX) raw[bus.in] <= raw[bus.in] + RAW_WIDTH'(1);
                  if (bus.in_last) begin
                     state    <= ST_SCAN;
                     idx      <= '0;
                     max_q    <= '0;
                     in_rdy_q <= 1'b0;
                     busy_q   <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (scan_tail) begin
                  state     <= ST_EMIT;
                  idx       <= '0;
                  out_vld_q <= 1'b1;
                  out_q     <= norm_val;
               end else begin
                  max_q <= scan_max;
                  idx   <= idx + IDX_WIDTH'(1);
                  if (pos == LAST_SYM) shift_q <= calc_shift(scan_max);
               end
            end
            ST_EMIT: begin
               if (bus.out_rdy) begin
                  raw[pos] <= '0;
                  if (pos == LAST_SYM) begin
                     state     <= ST_COUNT;
                     idx       <= '0;
                     max_q     <= '0;
                     shift_q   <= '0;
                     in_rdy_q  <= 1'b1;
                     out_vld_q <= 1'b0;
                     busy_q    <= 1'b0;
                     out_q     <= '0;
                  end else begin
                     idx   <= idx + IDX_WIDTH'(1);
                     out_q <= norm_val;
                  end
               end
            end
            default: begin
               state <= ST_COUNT;
            end
         endcase
      end
   end

   assign bus.in_rdy  = in_rdy_q;
   assign bus.out_vld = out_vld_q;
   assign bus.out     = out_q;
   assign bus.busy    = busy_q;

endmodule
